imem_dmem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the fetch stage (instruction requester) and the load/store unit (data requester). Fixed data priority with a fetch starvation guard. One outstanding memory transaction at a time. Fetch responses can be squashed on branch redirect. Sits between the Samsun_Core fetch/LSU and the memory model or bus bridge.

---
 rtl/imem_dmem_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and the load/store unit.
// Data side has fixed priority; a streak counter forces a fetch grant to prevent starvation.
module imem_dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // fetch request / response
  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [31:0] if_req_addr_i,
  input  logic        if_flush_i,
  output logic        if_rsp_valid_o,
  output logic [31:0] if_rsp_addr_o,
  output logic [31:0] if_rsp_instr_o,
  // load/store request / response
  input  logic        ls_req_valid_i,
  output logic        ls_req_ready_o,
  input  logic [31:0] ls_req_addr_i,
  input  logic        ls_req_we_i,
  input  logic [3:0]  ls_req_be_i,
  input  logic [31:0] ls_req_wdata_i,
  output logic        ls_rsp_valid_o,
  output logic [31:0] ls_rsp_rdata_o,
  // memory side
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  output logic        mem_req_we_o,
  output logic [3:0]  mem_req_be_o,
  output logic [31:0] mem_req_wdata_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [3:0] StreakMax = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;

  logic        owner_ls_q;
  logic [3:0]  streak_q;
  logic        drop_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        if_rsp_valid_q;
  logic [31:0] if_rsp_addr_q;
  logic [31:0] if_rsp_instr_q;
  logic        ls_rsp_valid_q;
  logic [31:0] ls_rsp_rdata_q;

  logic        in_idle;
  logic        force_fetch;
  logic        grant_if;
  logic        grant_ls;
  logic        grant_any;
  logic        rsp_take;
  logic        flush_hit;
  logic        drop_now;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    in_idle     = (state_q == StIdle) && !rst_i;
    force_fetch = if_req_valid_i && (streak_q == StreakMax);
    grant_ls    = in_idle && ls_req_valid_i && !force_fetch;
    grant_if    = in_idle && if_req_valid_i && !grant_ls;
    grant_any   = grant_if || grant_ls;
  end

  // A flush only matters while a fetch transaction is in flight; the request
  // itself is never retracted, only its response is swallowed.
  always_comb begin
    flush_hit = if_flush_i && !owner_ls_q && ((state_q == StIssue) || (state_q == StWait));
    drop_now  = drop_q || flush_hit;
    rsp_take  = (state_q == StWait) && mem_rsp_valid_i;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    if_req_ready_o  = grant_if;
    ls_req_ready_o  = grant_ls;
    mem_req_valid_o = (state_q == StIssue);
    mem_req_addr_o  = addr_q;
    mem_req_we_o    = we_q;
    mem_req_be_o    = be_q;
    mem_req_wdata_o = wdata_q;
  end

  // ---------------------------------------------------------------------------
  // Latched request fields and owner
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else if (grant_any) begin
      owner_ls_q <= grant_ls;
      addr_q     <= grant_ls ? ls_req_addr_i : if_req_addr_i;
      we_q       <= grant_ls && ls_req_we_i;
      be_q       <= (grant_ls && ls_req_we_i) ? ls_req_be_i : 4'hF;
      wdata_q    <= (grant_ls && ls_req_we_i) ? ls_req_wdata_i : 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation streak: counts LSU wins while fetch was left waiting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else if (grant_ls && if_req_valid_i) begin
      if (streak_q != StreakMax) begin
        streak_q <= streak_q + 4'd1;
      end
    end else if (grant_any) begin
      streak_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch squash flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= 1'b0;
    end else if (rsp_take || (state_q == StIdle)) begin
      drop_q <= 1'b0;
    end else if (flush_hit) begin
      drop_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_rsp_valid_q <= 1'b0;
      if_rsp_addr_q  <= '0;
      if_rsp_instr_q <= '0;
    end else begin
      if_rsp_valid_q <= rsp_take && !owner_ls_q && !drop_now;
      if (rsp_take && !owner_ls_q && !drop_now) begin
        if_rsp_addr_q  <= addr_q;
        if_rsp_instr_q <= mem_rsp_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_rdata_q <= '0;
    end else begin
      ls_rsp_valid_q <= rsp_take && owner_ls_q;
      if (rsp_take && owner_ls_q) begin
        ls_rsp_rdata_q <= we_q ? 32'h0 : mem_rsp_rdata_i;
      end
    end
  end

  always_comb begin
    if_rsp_valid_o = if_rsp_valid_q;
    if_rsp_addr_o  = if_rsp_addr_q;
    if_rsp_instr_o = if_rsp_instr_q;
    ls_rsp_valid_o = ls_rsp_valid_q;
    ls_rsp_rdata_o = ls_rsp_rdata_q;
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench for imem_dmem_port_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_imem_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_flush;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_addr, if_rsp_instr;
  logic        ls_req_valid, ls_req_ready, ls_req_we;
  logic [31:0] ls_req_addr, ls_req_wdata;
  logic [3:0]  ls_req_be;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int checks = 0;
  int errors = 0;

  imem_dmem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_req_valid_i  (if_req_valid),
    .if_req_ready_o  (if_req_ready),
    .if_req_addr_i   (if_req_addr),
    .if_flush_i      (if_flush),
    .if_rsp_valid_o  (if_rsp_valid),
    .if_rsp_addr_o   (if_rsp_addr),
    .if_rsp_instr_o  (if_rsp_instr),
    .ls_req_valid_i  (ls_req_valid),
    .ls_req_ready_o  (ls_req_ready),
    .ls_req_addr_i   (ls_req_addr),
    .ls_req_we_i     (ls_req_we),
    .ls_req_be_i     (ls_req_be),
    .ls_req_wdata_i  (ls_req_wdata),
    .ls_rsp_valid_o  (ls_rsp_valid),
    .ls_rsp_rdata_o  (ls_rsp_rdata),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_we_o    (mem_req_we),
    .mem_req_be_o    (mem_req_be),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_rdata_i (mem_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    logic exp_ls;

    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0040; if_flush = 1'b0;
    ls_req_valid = 1'b1; ls_req_addr = 32'h0000_0200; ls_req_we = 1'b0;
    ls_req_be = 4'h0; ls_req_wdata = 32'h0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;

    // Reset held two cycles with both requesters asking
    next_cycle(); #1;
    chk("rst1_if_ready", 32'(if_req_ready), 32'd0);
    chk("rst1_ls_ready", 32'(ls_req_ready), 32'd0);
    next_cycle(); #1;
    chk("rst2_if_ready", 32'(if_req_ready), 32'd0);
    chk("rst2_ls_ready", 32'(ls_req_ready), 32'd0);
    chk("rst2_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rst2_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("rst2_ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);
    chk("rst2_mem_addr", mem_req_addr, 32'h0);
    rst = 1'b0; #1;
    chk("first_grant_ls", 32'(ls_req_ready), 32'd1);
    chk("first_grant_if", 32'(if_req_ready), 32'd0);

    // Load completes through the LSU path
    next_cycle(); ls_req_valid = 1'b0; if_req_valid = 1'b0; #1;
    chk("load_mem_valid", 32'(mem_req_valid), 32'd1);
    chk("load_mem_addr", mem_req_addr, 32'h0000_0200);
    chk("load_mem_we", 32'(mem_req_we), 32'd0);
    chk("load_mem_be", 32'(mem_req_be), 32'hF);
    chk("issue_ls_ready", 32'(ls_req_ready), 32'd0);
    next_cycle(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D; #1;
    chk("load_wait_mem_valid", 32'(mem_req_valid), 32'd0);
    next_cycle(); mem_rsp_valid = 1'b0; #1;
    chk("load_rsp_valid", 32'(ls_rsp_valid), 32'd1);
    chk("load_rsp_rdata", ls_rsp_rdata, 32'hCAFE_F00D);
    chk("load_no_if_rsp", 32'(if_rsp_valid), 32'd0);

    // Single fetch: grant N, issue N+1, memory N+2, response N+3
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0008; #1;
    chk("fetch_ready", 32'(if_req_ready), 32'd1);
    next_cycle(); if_req_valid = 1'b0; #1;
    chk("load_rsp_pulse_end", 32'(ls_rsp_valid), 32'd0);
    chk("fetch_mem_valid", 32'(mem_req_valid), 32'd1);
    chk("fetch_mem_addr", mem_req_addr, 32'h0000_0008);
    chk("fetch_mem_be", 32'(mem_req_be), 32'hF);
    chk("fetch_mem_we", 32'(mem_req_we), 32'd0);
    next_cycle(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0050_0093; #1;
    chk("fetch_rsp_early", 32'(if_rsp_valid), 32'd0);
    next_cycle(); mem_rsp_valid = 1'b0; #1;
    chk("fetch_rsp_valid", 32'(if_rsp_valid), 32'd1);
    chk("fetch_rsp_addr", if_rsp_addr, 32'h0000_0008);
    chk("fetch_rsp_instr", if_rsp_instr, 32'h0050_0093);

    // Store: byte enables and data pass through, response data forced to 0
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h0000_0100;
    ls_req_be = 4'b0011; ls_req_wdata = 32'hDEAD_BEEF; #1;
    chk("store_ready", 32'(ls_req_ready), 32'd1);
    next_cycle(); ls_req_valid = 1'b0; #1;
    chk("fetch_rsp_pulse_end", 32'(if_rsp_valid), 32'd0);
    chk("store_mem_we", 32'(mem_req_we), 32'd1);
    chk("store_mem_be", 32'(mem_req_be), 32'h3);
    chk("store_mem_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    chk("store_mem_addr", mem_req_addr, 32'h0000_0100);
    next_cycle(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678; #1;
    next_cycle(); mem_rsp_valid = 1'b0; #1;
    chk("store_rsp_valid", 32'(ls_rsp_valid), 32'd1);
    chk("store_rsp_rdata", ls_rsp_rdata, 32'h0);

    // Starvation: both requesters held; expect LSU x4, fetch, LSU x4, fetch
    rst = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h0000_0300;
    next_cycle(); rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0020; ls_req_valid = 1'b1; #1;
    for (int g = 0; g < 10; g++) begin
      exp_ls = !(g == 4 || g == 9);
      chk($sformatf("starve_ls_grant%0d", g), 32'(ls_req_ready), 32'(exp_ls));
      chk($sformatf("starve_if_grant%0d", g), 32'(if_req_ready), 32'(!exp_ls));
      next_cycle();
      next_cycle(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0001;
      next_cycle(); mem_rsp_valid = 1'b0; #1;
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;

    // Flush while the fetch sits in ISSUE under backpressure
    mem_req_ready = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h0000_0010; #1;
    chk("flush_fetch_ready", 32'(if_req_ready), 32'd1);
    next_cycle(); if_req_valid = 1'b0; if_flush = 1'b1; #1;
    chk("flush_mem_valid0", 32'(mem_req_valid), 32'd1);
    chk("flush_mem_addr", mem_req_addr, 32'h0000_0010);
    next_cycle(); if_flush = 1'b0; #1;
    chk("flush_mem_valid1", 32'(mem_req_valid), 32'd1);
    next_cycle(); #1;
    chk("flush_mem_valid2", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    next_cycle(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0_BAD0; #1;
    chk("flush_wait_mem_valid", 32'(mem_req_valid), 32'd0);
    next_cycle(); mem_rsp_valid = 1'b0; #1;
    chk("flush_rsp_squashed", 32'(if_rsp_valid), 32'd0);

    // Next fetch, presented together with an IDLE flush, returns normally
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0004; if_flush = 1'b1; #1;
    chk("refetch_ready", 32'(if_req_ready), 32'd1);
    next_cycle(); if_req_valid = 1'b0; if_flush = 1'b0; #1;
    chk("flush_rsp_still_low", 32'(if_rsp_valid), 32'd0);
    next_cycle(); mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0013;
    next_cycle(); mem_rsp_valid = 1'b0; #1;
    chk("refetch_rsp_valid", 32'(if_rsp_valid), 32'd1);
    chk("refetch_rsp_addr", if_rsp_addr, 32'h0000_0004);
    chk("refetch_rsp_instr", if_rsp_instr, 32'h0000_0013);

    // Reset during WAIT, then a stale memory response
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h0000_0300; #1;
    chk("midrst_ls_ready", 32'(ls_req_ready), 32'd1);
    next_cycle(); ls_req_valid = 1'b0;
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0055; #1;
    chk("midrst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_ls_rsp0", 32'(ls_rsp_valid), 32'd0);
    next_cycle(); mem_rsp_valid = 1'b0; #1;
    chk("stale_ls_rsp", 32'(ls_rsp_valid), 32'd0);
    chk("stale_if_rsp", 32'(if_rsp_valid), 32'd0);
    chk("stale_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("stale_ls_rdata", ls_rsp_rdata, 32'h0);
    ls_req_valid = 1'b1; #1;
    chk("stale_idle_grant", 32'(ls_req_ready), 32'd1);
    next_cycle(); ls_req_valid = 1'b0; #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
